// File: rtl/seg_dynamic_n.sv
// seg_dynamic_n - multiplexed seven-segment driver for common-anode digits.
// The display value arrives as an unsigned magnitude with a separate sign.
// A free-running shift-add-3 converter produces the BCD digits. The driver
// also handles leading-zero blanking, decimal points, the minus sign, the
// overflow pattern and per-digit blinking.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   data [DATA_W]      : magnitude to display
//   sign               : 1 = negative
//   point [DIGITS]     : decimal point enable per digit (bit 0 = units)
//   blink [DIGITS]     : per-digit blink mask
//   seg_en             : display enable
//   sel [DIGITS]       : one-hot digit select, active-high (bit 0 = units)
//   seg [8]            : segments, active-low, {dp,g,f,e,d,c,b,a}
//   ovf                : overflow flag of the last committed conversion
//   conv_done          : one-cycle pulse when a conversion commits
//
// Converter states:
//   state   | meaning
//   S_LOAD  | capture data/sign/point, clear BCD, arm bit counter
//   S_SHIFT | one add-3 + shift step per cycle, DATA_W cycles
//   S_DONE  | commit BCD, sign, points and overflow to the display register
module seg_dynamic_n #(
    parameter int DIGITS    = 6,
    parameter int DATA_W    = 20,
    parameter int CNT_MAX   = 49_999,
    parameter int BLINK_MAX = 249
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              sign,
    input  logic [DIGITS-1:0] point,
    input  logic [DIGITS-1:0] blink,
    input  logic              seg_en,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg,
    output logic              ovf,
    output logic              conv_done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(CNT_MAX + 2);
    localparam int BLK_W = $clog2(BLINK_MAX + 2);

    function automatic logic [63:0] pow10(input int e);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < e; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIM_POS = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1) - 64'd1;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                sign_cap_q, sign_cap_d;
    logic [DIGITS-1:0]   point_cap_q, point_cap_d;
    logic                ovf_cap_q, ovf_cap_d;
    logic [BCD_W-1:0]    disp_bcd_q, disp_bcd_d;
    logic                disp_sign_q, disp_sign_d;
    logic [DIGITS-1:0]   disp_point_q, disp_point_d;
    logic                ovf_q, ovf_d;
    logic                conv_done_q, conv_done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]          seg_q, seg_d;

    logic [63:0]         data_ext;
    logic                tick;
    logic                acc;
    logic [DIGITS-1:0]   sig;
    logic [DIGITS-1:0]   sig_below;
    logic                nonzero;
    logic [7:0]          pat [DIGITS];

    assign data_ext = {{(64 - DATA_W){1'b0}}, data};

    // Converter: next state, shift/add-3 datapath and display commit.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        bcd_d        = bcd_q;
        bit_d        = bit_q;
        sign_cap_d   = sign_cap_q;
        point_cap_d  = point_cap_q;
        ovf_cap_d    = ovf_cap_q;
        disp_bcd_d   = disp_bcd_q;
        disp_sign_d  = disp_sign_q;
        disp_point_d = disp_point_q;
        ovf_d        = ovf_q;
        conv_done_d  = 1'b0;

        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            S_LOAD: begin
                sh_d        = data;
                bcd_d       = '0;
                bit_d       = BIT_W'(DATA_W - 1);
                sign_cap_d  = sign;
                point_cap_d = point;
                // A negative value gives up the top digit to the minus sign.
                ovf_cap_d   = sign ? (data_ext > LIM_NEG) : (data_ext > LIM_POS);
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                // Carry out of the top nibble is dropped; overflow covers it.
                bcd_d = {bcd_adj[BCD_W-2:0], sh_q[DATA_W-1]};
                sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                if (bit_q == '0) state_d = S_DONE;
                else             bit_d   = bit_q - 1'b1;
            end
            S_DONE: begin
                disp_bcd_d   = bcd_q;
                disp_sign_d  = sign_cap_q;
                disp_point_d = point_cap_q;
                ovf_d        = ovf_cap_q;
                conv_done_d  = 1'b1;
                state_d      = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Significance: everything at or below the highest nonzero digit or point.
    always_comb begin
        sig = '0;
        acc = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc    = acc | (disp_bcd_q[4*i +: 4] != 4'd0) | disp_point_q[i];
            sig[i] = acc;
        end
        sig[0] = 1'b1;
    end

    assign sig_below = {sig[DIGITS-2:0], 1'b0};
    assign nonzero   = |disp_bcd_q;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            pat[i] = 8'hFF;
            if (ovf_q)
                pat[i] = 8'h86;
            else if (blink[i] && blink_ph_q)
                pat[i] = 8'hFF;
            else if (sig[i])
                pat[i] = {~disp_point_q[i], glyph(disp_bcd_q[4*i +: 4])};
            else if (disp_sign_q && nonzero && sig_below[i])
                pat[i] = 8'hBF;
        end
    end

    // Scan timing, blink phase and registered digit outputs.
    assign tick = (cnt_q == CNT_W'(CNT_MAX));

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        sel_d       = sel_q;
        seg_d       = seg_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            if (blink_cnt_q == BLK_W'(BLINK_MAX)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
            if (seg_en) begin
                sel_d = DIGITS'(1) << idx_d;
                seg_d = pat[idx_d];
            end else begin
                sel_d = '0;
                seg_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_LOAD;
            sh_q         <= '0;
            bcd_q        <= '0;
            bit_q        <= '0;
            sign_cap_q   <= 1'b0;
            point_cap_q  <= '0;
            ovf_cap_q    <= 1'b0;
            disp_bcd_q   <= '0;
            disp_sign_q  <= 1'b0;
            disp_point_q <= '0;
            ovf_q        <= 1'b0;
            conv_done_q  <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            sel_q        <= '0;
            seg_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            bcd_q        <= bcd_d;
            bit_q        <= bit_d;
            sign_cap_q   <= sign_cap_d;
            point_cap_q  <= point_cap_d;
            ovf_cap_q    <= ovf_cap_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_sign_q  <= disp_sign_d;
            disp_point_q <= disp_point_d;
            ovf_q        <= ovf_d;
            conv_done_q  <= conv_done_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
        end
    end

    assign sel       = sel_q;
    assign seg       = seg_q;
    assign ovf       = ovf_q;
    assign conv_done = conv_done_q;

endmodule

// File: tb/tb_seg_dynamic_n.sv
// Testbench for seg_dynamic_n. Conversions are scheduled by time: one capture
// every DATA_W+2 cycles. Each capture pushes the sampled inputs into a queue.
// A negedge monitor pops an entry on every conv_done and checks ovf. It then
// uses that entry as the model's display contents. Each scan tick the expected
// sel/seg come from decimal arithmetic on that value; otherwise they must hold.
module tb_seg_dynamic_n;
    localparam int DIGITS    = 6;
    localparam int DATA_W    = 20;
    localparam int CNT_MAX   = 9;
    localparam int BLINK_MAX = 1;
    localparam int P         = DATA_W + 2;
    localparam int TP        = CNT_MAX + 1;

    localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b1;
    logic [DATA_W-1:0] data = '0;
    logic              sign = 1'b0;
    logic [DIGITS-1:0] point = '0;
    logic [DIGITS-1:0] blink = '0;
    logic              seg_en = 1'b1;
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;
    logic              ovf;
    logic              conv_done;

    seg_dynamic_n #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .CNT_MAX(CNT_MAX), .BLINK_MAX(BLINK_MAX)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .sign(sign),
        .point(point), .blink(blink), .seg_en(seg_en), .sel(sel), .seg(seg),
        .ovf(ovf), .conv_done(conv_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int                v;
        bit                s;
        logic [DIGITS-1:0] p;
    } conv_t;

    conv_t             exp_q[$];
    conv_t             disp_m;
    conv_t             popped;
    int                n = 0;
    int                tcount = 0;
    int                total = 0;
    int                bad = 0;
    int                idx;
    bit                ph;
    logic [DIGITS-1:0] exp_sel = '0;
    logic [7:0]        exp_seg = 8'hFF;

    function automatic int p10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic bit ovf_of(input conv_t c);
        return c.s ? (c.v > p10(DIGITS - 1) - 1) : (c.v > p10(DIGITS) - 1);
    endfunction

    function automatic logic [7:0] pattern(input conv_t c, input int i, input bit phase,
                                           input logic [DIGITS-1:0] bl);
        int top = 0;
        int d;
        for (int j = 0; j < DIGITS; j++)
            if (((c.v / p10(j)) % 10) != 0 || c.p[j]) top = j;
        d = (c.v / p10(i)) % 10;
        if (ovf_of(c))          return 8'h86;
        if (bl[i] && phase)     return 8'hFF;
        if (i <= top)           return {~c.p[i], GLYPH[d]};
        if (c.s && c.v != 0 && i == top + 1) return 8'hBF;
        return 8'hFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, act, expv);
        end
    endtask

    // Capture schedule and scan-tick expectations.
    always @(posedge sys_clk) begin
        if (sys_rst_n) begin
            n++;
            if ((n - 1) % P == 0) exp_q.push_back('{int'(data), sign, point});
            if (n % TP == 0) begin
                tcount++;
                idx = tcount % DIGITS;
                ph  = (((tcount - 1) / (BLINK_MAX + 1)) % 2) == 1;
                if (seg_en) begin
                    exp_sel = DIGITS'(1) << idx;
                    exp_seg = pattern(disp_m, idx, ph, blink);
                end else begin
                    exp_sel = '0;
                    exp_seg = 8'hFF;
                end
            end
        end
    end

    // Monitor: outputs every cycle, scoreboard pop on each commit.
    always @(negedge sys_clk) begin
        if (sys_rst_n && n > 0) begin
            chk("sel", 32'(sel), 32'(exp_sel));
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("conv_done", 32'(conv_done), 32'(n % P == 0));
            if (conv_done) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    popped = exp_q.pop_front();
                    disp_m = popped;
                end
            end
            chk("ovf", 32'(ovf), 32'(ovf_of(disp_m)));
        end
    end

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_conv_done", 32'(conv_done), 32'd0);
        n = 0;
        tcount = 0;
        exp_q.delete();
        disp_m = '{0, 1'b0, '0};
        exp_sel = '0;
        exp_seg = 8'hFF;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic hold(input int v, input bit s, input logic [DIGITS-1:0] p,
                        input logic [DIGITS-1:0] bl, input int cycles);
        data  = DATA_W'(v);
        sign  = s;
        point = p;
        blink = bl;
        repeat (cycles) @(negedge sys_clk);
    endtask

    function automatic int rand_val();
        return $urandom % p10($urandom_range(1, 7));
    endfunction

    initial begin
        #2;
        do_reset();
        hold(12345,     1'b0, 6'b000000, 6'b000000, 150);
        hold(5,         1'b1, 6'b000100, 6'b000000, 150);
        hold(1_000_000, 1'b0, 6'b000000, 6'b000000, 120);
        hold(100_000,   1'b1, 6'b000000, 6'b000000, 120);
        hold(99_999,    1'b1, 6'b000000, 6'b000000, 150);
        hold(0,         1'b1, 6'b000000, 6'b000000, 120);
        hold(7,         1'b0, 6'b000000, 6'b000001, 200);
        // Display disable mid-scan, then re-enable.
        hold(4321,      1'b1, 6'b000010, 6'b000000, 63);
        seg_en = 1'b0;
        repeat (37) @(negedge sys_clk);
        seg_en = 1'b1;
        repeat (80) @(negedge sys_clk);
        // Fast-changing data: one new value every 5 cycles.
        for (int k = 0; k < 40; k++) begin
            data = DATA_W'(rand_val());
            sign = 1'($urandom);
            repeat (5) @(negedge sys_clk);
        end
        // Broader random patterns.
        for (int k = 0; k < 30; k++) begin
            seg_en = ($urandom_range(0, 4) != 0);
            hold(rand_val(), 1'($urandom), DIGITS'($urandom) & DIGITS'($urandom),
                 DIGITS'($urandom), 60);
        end
        seg_en = 1'b1;
        // Reset while the converter is shifting.
        for (int k = 0; k < 2 * P && (n % P) != 6; k++) @(negedge sys_clk);
        chk("reach_shift", 32'(n % P), 32'd6);
        #2;
        do_reset();
        hold(271828, 1'b0, 6'b001000, 6'b000000, 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
